alu_uart_sequencer: RTL

ALU_UART_SEQUENCER -- requirements
Module: alu_uart_sequencer

---
 rtl/alu_uart_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_uart_sequencer.sv
// ---------------------------------------------------------------------------
// alu_uart_sequencer
//
// Collects an ALU frame from a byte-wide UART receiver, presents it to an
// external combinational ALU and streams the result back out through a
// byte-wide UART transmitter.
//
// Frame on the wire: NB bytes of A, NB bytes of B, one opcode byte.
// Multi-byte operands and results travel least-significant byte first.
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous, active-low reset
//   d_in      : received byte, valid while rx_done is high
//   rx_done   : one-cycle pulse, d_in valid
//   rx_error  : one-cycle pulse, receiver framing/parity error
//   tx_done   : one-cycle pulse, transmitter finished current byte
//   alu_res   : combinational ALU result for the current a, b, op
//   a, b, op  : ALU operands and opcode (change only on frame completion)
//   tx_start  : one-cycle pulse, transmit d_out
//   d_out     : byte to transmit
//   busy      : frame in progress (first byte of A .. final tx_done)
//   err       : one-cycle pulse on any error
//   err_code  : last error (00 none, 01 rx_error, 10 timeout, 11 overrun)
// ---------------------------------------------------------------------------
module alu_uart_sequencer #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        d_in,
  input  logic              rx_done,
  input  logic              rx_error,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [7:0]        op,
  output logic              tx_start,
  output logic [7:0]        d_out,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  localparam logic [31:0]   IDLE_LIMIT = 32'(TIMEOUT - 1);
  localparam bit            TMO_EN = (TIMEOUT != 0);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_RX   = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_OVR  = 2'b11;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     k_q, k_d;
  logic [CW-1:0]     j_q, j_d;
  logic [31:0]       idle_q, idle_d;
  logic [DATA_W-1:0] a_sh_q, a_sh_d;
  logic [DATA_W-1:0] b_sh_q, b_sh_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [7:0]        op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        d_out_q, d_out_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              tmo_active_s;
  logic              tmo_hit_s;
  logic              abort_s;
  logic [1:0]        abort_code_s;

  // Select byte idx (LSB first) out of a DATA_W-wide word.
  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] v,
                                           input logic [CW-1:0]     idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (idx == CW'(i)) begin
        r = v[8*i +: 8];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Write byte idx (LSB first) of a DATA_W-wide word, leaving the rest intact.
  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] v,
                                                 input logic [CW-1:0]     idx,
                                                 input logic [7:0]        byte_in);
    logic [DATA_W-1:0] r;
    r = v;
    for (int i = 0; i < NB; i++) begin
      if (idx == CW'(i)) begin
        r[8*i +: 8] = byte_in;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Inter-byte timeout is only armed once a frame has started receiving.
  always_comb begin
    tmo_active_s = 1'b0;
    if (TMO_EN) begin
      tmo_active_s = ((state_q == GET_A) && (k_q != {CW{1'b0}})) ||
                     (state_q == GET_B) || (state_q == GET_OP);
    end else begin
      tmo_active_s = 1'b0;
    end
    tmo_hit_s = tmo_active_s && (idle_q == IDLE_LIMIT);
  end

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    j_d          = j_q;
    idle_d       = 32'd0;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    tx_start_d   = 1'b0;
    d_out_d      = d_out_q;
    busy_d       = busy_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    abort_s      = 1'b0;
    abort_code_s = ERR_NONE;

    case (state_q)
      GET_A, GET_B, GET_OP: begin
        // rx_error outranks a simultaneous rx_done: the byte is dropped.
        if (rx_error) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_RX;
        end else if (rx_done) begin
          idle_d = 32'd0;
          case (state_q)
            GET_A: begin
              a_sh_d = put_byte(a_sh_q, k_q, d_in);
              if (k_q == {CW{1'b0}}) begin
                busy_d = 1'b1;
              end else begin
                busy_d = busy_q;
              end
              if (k_q == LAST_BYTE) begin
                k_d     = {CW{1'b0}};
                state_d = GET_B;
              end else begin
                k_d = k_q + {{(CW-1){1'b0}}, 1'b1};
              end
            end
            GET_B: begin
              b_sh_d = put_byte(b_sh_q, k_q, d_in);
              if (k_q == LAST_BYTE) begin
                k_d     = {CW{1'b0}};
                state_d = GET_OP;
              end else begin
                k_d = k_q + {{(CW-1){1'b0}}, 1'b1};
              end
            end
            default: begin
              // Opcode byte: the final B byte already sits in its shadow, so
              // all three ALU inputs update together on this edge. The opcode
              // is taken straight from the accepted byte.
              a_d     = a_sh_q;
              b_d     = b_sh_q;
              op_d    = d_in;
              state_d = EXEC;
            end
          endcase
        end else if (tmo_hit_s) begin
          abort_s      = 1'b1;
          abort_code_s = ERR_TMO;
        end else if (tmo_active_s) begin
          idle_d = idle_q + 32'd1;
        end else begin
          idle_d = 32'd0;
        end
      end

      EXEC: begin
        // Result byte 0 comes from alu_res directly since res_q is loaded
        // on this same edge.
        res_d      = alu_res;
        d_out_d    = pick_byte(alu_res, {CW{1'b0}});
        tx_start_d = 1'b1;
        j_d        = {CW{1'b0}};
        state_d    = SEND;
      end

      SEND: begin
        state_d = WAIT_TX;
      end

      WAIT_TX: begin
        if (tx_done) begin
          if (j_q == LAST_BYTE) begin
            busy_d  = 1'b0;
            state_d = GET_A;
          end else begin
            j_d        = j_q + {{(CW-1){1'b0}}, 1'b1};
            d_out_d    = pick_byte(res_q, j_q + {{(CW-1){1'b0}}, 1'b1});
            tx_start_d = 1'b1;
            state_d    = SEND;
          end
        end else begin
          state_d = WAIT_TX;
        end
      end

      default: begin
        state_d = GET_A;
        k_d     = {CW{1'b0}};
        busy_d  = 1'b0;
      end
    endcase

    // A byte arriving while the result is being sent is flagged and dropped;
    // rx_error alone is ignored in these states.
    if ((state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX)) begin
      if (rx_done && !rx_error) begin
        err_d      = 1'b1;
        err_code_d = ERR_OVR;
      end else begin
        err_d = 1'b0;
      end
    end else begin
      err_d = err_d;
    end

    // Receive-side abort: drop the partial frame, keep a/b/op untouched.
    if (abort_s) begin
      state_d    = GET_A;
      k_d        = {CW{1'b0}};
      idle_d     = 32'd0;
      a_sh_d     = {DATA_W{1'b0}};
      b_sh_d     = {DATA_W{1'b0}};
      busy_d     = 1'b0;
      err_d      = 1'b1;
      err_code_d = abort_code_s;
    end else begin
      err_code_d = err_code_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= GET_A;
      k_q        <= {CW{1'b0}};
      j_q        <= {CW{1'b0}};
      idle_q     <= 32'd0;
      a_sh_q     <= {DATA_W{1'b0}};
      b_sh_q     <= {DATA_W{1'b0}};
      a_q        <= {DATA_W{1'b0}};
      b_q        <= {DATA_W{1'b0}};
      op_q       <= 8'h00;
      res_q      <= {DATA_W{1'b0}};
      tx_start_q <= 1'b0;
      d_out_q    <= 8'h00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      j_q        <= j_d;
      idle_q     <= idle_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      tx_start_q <= tx_start_d;
      d_out_q    <= d_out_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign op       = op_q;
  assign tx_start = tx_start_q;
  assign d_out    = d_out_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
